axis_packet_sender: RTL and testbench

Consumes `{channel, pause, length}` descriptors from the descriptor generator over a valid/ready handshake. For each descriptor it emits one AXI-Stream packet of `length` bytes on TID `channel`, carrying a deterministic byte-counter payload. It then idles for `pause` clock cycles before accepting the next descriptor. It is the sink end of the descriptor interface and the data-path head of the traffic generator.

---
 rtl/axis_gen_pkg.sv | 29 ++
 rtl/axis_tkeep_calc.sv | 20 ++
 rtl/axis_packet_sender.sv | 210 +++++++++++++++++++++
 tb/tb_axis_packet_sender.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_gen_pkg.sv
// Shared definitions for the traffic generator: descriptor layout and sender state encoding.
package axis_gen_pkg;

  localparam int unsigned DESCR_LEN_LSB   = 0;
  localparam int unsigned DESCR_LEN_W     = 16;
  localparam int unsigned DESCR_PAUSE_LSB = 16;
  localparam int unsigned DESCR_PAUSE_W   = 32;
  localparam int unsigned DESCR_CH_LSB    = 48;

  // Low 48 bits of every descriptor; the channel of width ID_WIDTH sits above DESCR_CH_LSB.
  typedef struct packed {
    logic [DESCR_PAUSE_W-1:0] pause;
    logic [DESCR_LEN_W-1:0]   length;
  } descr_base_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SEND  = 2'd1,
    ST_PAUSE = 2'd2
  } sender_state_t;

  function automatic logic [DESCR_CH_LSB-1:0] descr_pack_base(
    input logic [DESCR_PAUSE_W-1:0] pause,
    input logic [DESCR_LEN_W-1:0]   length
  );
    return {pause, length};
  endfunction

endpackage

// File: rtl/axis_tkeep_calc.sv
// Byte-enable generator: all lanes on every beat except a partial final beat.
module axis_tkeep_calc #(
  parameter int unsigned BYTES = 4,
  parameter int unsigned REM_W = 2
) (
  input  logic [REM_W-1:0] rem_i,
  input  logic             last_i,
  output logic [BYTES-1:0] tkeep_c_o
);

  always_comb begin
    tkeep_c_o = '1;
    if (last_i && (rem_i != '0)) begin
      for (int unsigned j = 0; j < BYTES; j++) begin
        tkeep_c_o[j] = (REM_W'(j) < rem_i);
      end
    end
  end

endmodule

// File: rtl/axis_packet_sender.sv
// Turns {channel, pause, length} descriptors into AXI-Stream packets with a byte-counter
// payload, followed by an idle gap of `pause` cycles.
module axis_packet_sender
  import axis_gen_pkg::*;
#(
  parameter int unsigned ID_WIDTH   = 10,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [DESCR_CH_LSB+ID_WIDTH-1:0] descriptor_data_i,
  input  logic                       descriptor_valid_i,
  output logic                       descriptor_ready_o,
  output logic [DATA_WIDTH-1:0]      m_axis_tdata_o,
  output logic [DATA_WIDTH/8-1:0]    m_axis_tkeep_o,
  output logic [ID_WIDTH-1:0]        m_axis_tid_o,
  output logic                       m_axis_tlast_o,
  output logic                       m_axis_tvalid_o,
  input  logic                       m_axis_tready_i,
  output logic [31:0]                pkt_count_o,
  output logic                       busy_o
);

  localparam int unsigned BYTES = DATA_WIDTH / 8;
  localparam int unsigned REM_W = (BYTES > 1) ? $clog2(BYTES) : 1;

  sender_state_t         state_q, state_d;
  logic [31:0]           pause_q, pause_d;
  logic [31:0]           pause_cnt_q, pause_cnt_d;
  logic [15:0]           beats_q, beats_d;
  logic [15:0]           beat_q, beat_d;
  logic [REM_W-1:0]      rem_q, rem_d;
  logic [7:0]            byte_q, byte_d;
  logic [DATA_WIDTH-1:0] tdata_q, tdata_d;
  logic [BYTES-1:0]      tkeep_q, tkeep_d;
  logic [ID_WIDTH-1:0]   tid_q, tid_d;
  logic                  tlast_q, tlast_d;
  logic                  tvalid_q, tvalid_d;
  logic                  ready_q, ready_d;
  logic                  busy_q, busy_d;
  logic [31:0]           pkt_count_q, pkt_count_d;

  descr_base_t           descr_base;
  logic [ID_WIDTH-1:0]   descr_ch;
  logic [15:0]           descr_beats;
  logic [REM_W-1:0]      descr_rem;
  logic                  accept;
  logic                  handshake;

  logic [REM_W-1:0]      kc_rem;
  logic                  kc_last;
  logic [BYTES-1:0]      kc_keep;
  logic [7:0]            next_base;
  logic [DATA_WIDTH-1:0] next_data;

  assign descr_base  = descr_base_t'(descriptor_data_i[DESCR_CH_LSB-1:0]);
  assign descr_ch    = descriptor_data_i[DESCR_CH_LSB +: ID_WIDTH];
  assign descr_beats = 16'((17'(descr_base.length) + 17'(BYTES - 1)) / 17'(BYTES));
  assign descr_rem   = REM_W'(descr_base.length % 16'(BYTES));
  assign accept      = ready_q && descriptor_valid_i;
  assign handshake   = tvalid_q && m_axis_tready_i;

  // Describe the beat about to be loaded: beat 0 on accept, otherwise the successor of the current beat.
  always_comb begin
    if (state_q == ST_IDLE) begin
      kc_rem    = descr_rem;
      kc_last   = (descr_beats == 16'd1);
      next_base = 8'd0;
    end else begin
      kc_rem    = rem_q;
      kc_last   = ((beat_q + 16'd2) == beats_q);
      next_base = byte_q + 8'(BYTES);
    end
  end

  axis_tkeep_calc #(
    .BYTES (BYTES),
    .REM_W (REM_W)
  ) u_tkeep_calc (
    .rem_i     (kc_rem),
    .last_i    (kc_last),
    .tkeep_c_o (kc_keep)
  );

  // Unused lanes of a partial beat are driven to zero.
  always_comb begin
    next_data = '0;
    for (int unsigned j = 0; j < BYTES; j++) begin
      next_data[j*8 +: 8] = kc_keep[j] ? (next_base + 8'(j)) : 8'h00;
    end
  end

  always_comb begin
    state_d     = state_q;
    pause_d     = pause_q;
    pause_cnt_d = pause_cnt_q;
    beats_d     = beats_q;
    beat_d      = beat_q;
    rem_d       = rem_q;
    byte_d      = byte_q;
    tdata_d     = tdata_q;
    tkeep_d     = tkeep_q;
    tid_d       = tid_q;
    tlast_d     = tlast_q;
    tvalid_d    = tvalid_q;
    pkt_count_d = pkt_count_q;

    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          pause_d = descr_base.pause;
          beats_d = descr_beats;
          rem_d   = descr_rem;
          tid_d   = descr_ch;
          if (descr_base.length != 16'd0) begin
            state_d  = ST_SEND;
            beat_d   = 16'd0;
            byte_d   = 8'd0;
            tvalid_d = 1'b1;
            tdata_d  = next_data;
            tkeep_d  = kc_keep;
            tlast_d  = kc_last;
          end else if (descr_base.pause != 32'd0) begin
            state_d     = ST_PAUSE;
            pause_cnt_d = descr_base.pause;
          end
        end
      end
      ST_SEND: begin
        if (handshake) begin
          if (tlast_q) begin
            pkt_count_d = pkt_count_q + 32'd1;
            tvalid_d    = 1'b0;
            tlast_d     = 1'b0;
            if (pause_q != 32'd0) begin
              state_d     = ST_PAUSE;
              pause_cnt_d = pause_q;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            beat_d  = beat_q + 16'd1;
            byte_d  = next_base;
            tdata_d = next_data;
            tkeep_d = kc_keep;
            tlast_d = kc_last;
          end
        end
      end
      ST_PAUSE: begin
        pause_cnt_d = pause_cnt_q - 32'd1;
        if (pause_cnt_q == 32'd1) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    ready_d = (state_d == ST_IDLE);
    busy_d  = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      pause_q     <= '0;
      pause_cnt_q <= '0;
      beats_q     <= '0;
      beat_q      <= '0;
      rem_q       <= '0;
      byte_q      <= '0;
      tdata_q     <= '0;
      tkeep_q     <= '0;
      tid_q       <= '0;
      tlast_q     <= 1'b0;
      tvalid_q    <= 1'b0;
      ready_q     <= 1'b1;
      busy_q      <= 1'b0;
      pkt_count_q <= '0;
    end else begin
      state_q     <= state_d;
      pause_q     <= pause_d;
      pause_cnt_q <= pause_cnt_d;
      beats_q     <= beats_d;
      beat_q      <= beat_d;
      rem_q       <= rem_d;
      byte_q      <= byte_d;
      tdata_q     <= tdata_d;
      tkeep_q     <= tkeep_d;
      tid_q       <= tid_d;
      tlast_q     <= tlast_d;
      tvalid_q    <= tvalid_d;
      ready_q     <= ready_d;
      busy_q      <= busy_d;
      pkt_count_q <= pkt_count_d;
    end
  end

  assign descriptor_ready_o = ready_q;
  assign m_axis_tdata_o     = tdata_q;
  assign m_axis_tkeep_o     = tkeep_q;
  assign m_axis_tid_o       = tid_q;
  assign m_axis_tlast_o     = tlast_q;
  assign m_axis_tvalid_o    = tvalid_q;
  assign pkt_count_o        = pkt_count_q;
  assign busy_o             = busy_q;

endmodule

// File: tb/tb_axis_packet_sender.sv
// Scoreboard bench for axis_packet_sender: a byte-level packet model feeds expected beats,
// a monitor checks every handshake, stall stability, count updates and the ready gap.
module tb_axis_packet_sender;

  localparam int unsigned ID_W  = 10;
  localparam int unsigned DW    = 32;
  localparam int unsigned BYTES = DW / 8;

  typedef struct {
    logic [DW-1:0]    data;
    logic [BYTES-1:0] keep;
    logic             last;
    logic [ID_W-1:0]  tid;
  } beat_t;

  logic                 clk;
  logic                 reset;
  logic [48+ID_W-1:0]   descriptor_data;
  logic                 descriptor_valid;
  logic                 descriptor_ready_o;
  logic [DW-1:0]        m_axis_tdata_o;
  logic [BYTES-1:0]     m_axis_tkeep_o;
  logic [ID_W-1:0]      m_axis_tid_o;
  logic                 m_axis_tlast_o;
  logic                 m_axis_tvalid_o;
  logic                 m_axis_tready;
  logic [31:0]          pkt_count_o;
  logic                 busy_o;

  int          n_checks = 0;
  int          n_errs   = 0;
  bit          rnd_mode = 0;
  beat_t       exp_q[$];
  int unsigned pause_q[$];
  int unsigned exp_cnt = 0;

  axis_packet_sender #(
    .ID_WIDTH   (ID_W),
    .DATA_WIDTH (DW)
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .descriptor_data_i  (descriptor_data),
    .descriptor_valid_i (descriptor_valid),
    .descriptor_ready_o (descriptor_ready_o),
    .m_axis_tdata_o     (m_axis_tdata_o),
    .m_axis_tkeep_o     (m_axis_tkeep_o),
    .m_axis_tid_o       (m_axis_tid_o),
    .m_axis_tlast_o     (m_axis_tlast_o),
    .m_axis_tvalid_o    (m_axis_tvalid_o),
    .m_axis_tready_i    (m_axis_tready),
    .pkt_count_o        (pkt_count_o),
    .busy_o             (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: split the byte stream 0,1,2,... (mod 256) into BYTES-wide chunks.
  task automatic push_model(input logic [ID_W-1:0] ch, input logic [31:0] pause, input logic [15:0] len);
    beat_t       b;
    int unsigned n;
    n = int'(len);
    for (int unsigned base = 0; base < n; base += BYTES) begin
      b.data = '0;
      b.keep = '0;
      b.tid  = ch;
      b.last = (base + BYTES >= n);
      for (int unsigned j = 0; j < BYTES; j++) begin
        if (base + j < n) begin
          b.data[8*j +: 8] = 8'((base + j) % 256);
          b.keep[j]        = 1'b1;
        end
      end
      exp_q.push_back(b);
    end
    if (n != 0) pause_q.push_back(pause);
  endtask

  task automatic send_desc(input logic [ID_W-1:0] ch, input logic [31:0] pause, input logic [15:0] len);
    bit ok;
    ok = 1'b0;
    @(posedge clk);
    #1;
    descriptor_data  = {ch, pause, len};
    descriptor_valid = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (descriptor_ready_o) begin
        ok = 1'b1;
        break;
      end
    end
    check("desc_accept", 64'(ok), 64'd1);
    if (ok) begin
      push_model(ch, pause, len);
      @(posedge clk);
      #1;
      descriptor_valid = 1'b0;
      @(negedge clk);
      check("first_beat_latency", 64'(m_axis_tvalid_o), 64'(len != 16'd0));
      check("busy_after_accept", 64'(busy_o), 64'((len != 16'd0) || (pause != 32'd0)));
    end else begin
      descriptor_valid = 1'b0;
    end
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !busy_o && descriptor_ready_o) begin
        done = 1'b1;
        break;
      end
    end
    check("drain", 64'(done), 64'd1);
  endtask

  // Downstream ready: constant 1, or a fair coin each cycle.
  initial begin
    m_axis_tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      m_axis_tready = rnd_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: pops expectations on every handshake, independent of the stimulus thread.
  initial begin
    beat_t       e;
    beat_t       held;
    bit          stall;
    bit          gap_on;
    int unsigned gap;
    int unsigned gap_pause;
    stall  = 1'b0;
    gap_on = 1'b0;
    gap    = 0;
    gap_pause = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        exp_q.delete();
        pause_q.delete();
        exp_cnt = 0;
        stall   = 1'b0;
        gap_on  = 1'b0;
      end else begin
        if (gap_on) begin
          gap++;
          if (gap == 1) check("pkt_count", 64'(pkt_count_o), 64'(exp_cnt));
          if (descriptor_ready_o || gap > gap_pause) begin
            check("ready_gap_cycles", 64'(gap), 64'(gap_pause + 1));
            gap_on = 1'b0;
          end
        end
        if (stall) begin
          check("stall_hold",
                64'({m_axis_tvalid_o, m_axis_tlast_o, m_axis_tid_o, m_axis_tkeep_o, m_axis_tdata_o}),
                64'({1'b1, held.last, held.tid, held.keep, held.data}));
        end
        if (m_axis_tvalid_o && m_axis_tready) begin
          check("beat_expected", 64'(exp_q.size() != 0), 64'd1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("tdata", 64'(m_axis_tdata_o), 64'(e.data));
            check("tkeep", 64'(m_axis_tkeep_o), 64'(e.keep));
            check("tlast", 64'(m_axis_tlast_o), 64'(e.last));
            check("tid",   64'(m_axis_tid_o),   64'(e.tid));
            if (e.last) begin
              exp_cnt++;
              gap_on    = 1'b1;
              gap       = 0;
              gap_pause = (pause_q.size() != 0) ? pause_q.pop_front() : 0;
            end
          end
        end
        stall     = m_axis_tvalid_o && !m_axis_tready;
        held.data = m_axis_tdata_o;
        held.keep = m_axis_tkeep_o;
        held.last = m_axis_tlast_o;
        held.tid  = m_axis_tid_o;
      end
    end
  end

  initial begin
    reset            = 1'b1;
    descriptor_valid = 1'b0;
    descriptor_data  = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("rst_ready",  64'(descriptor_ready_o), 64'd1);
    check("rst_tvalid", 64'(m_axis_tvalid_o),    64'd0);
    check("rst_tlast",  64'(m_axis_tlast_o),     64'd0);
    check("rst_tdata",  64'(m_axis_tdata_o),     64'd0);
    check("rst_tkeep",  64'(m_axis_tkeep_o),     64'd0);
    check("rst_tid",    64'(m_axis_tid_o),       64'd0);
    check("rst_count",  64'(pkt_count_o),        64'd0);
    check("rst_busy",   64'(busy_o),             64'd0);

    // Basic packet, exact fit with pause, random backpressure.
    send_desc(10'd5, 32'd0, 16'd10);
    drain();
    send_desc(10'd3, 32'd4, 16'd8);
    drain();
    rnd_mode = 1'b1;
    send_desc(10'd7, 32'd1, 16'd37);
    drain();
    rnd_mode = 1'b0;

    // Zero length with a pause: no beats, busy for exactly two cycles.
    send_desc(10'd1, 32'd2, 16'd0);
    @(negedge clk);
    check("zl_busy2",   64'(busy_o),             64'd1);
    check("zl_ready2",  64'(descriptor_ready_o), 64'd0);
    @(negedge clk);
    check("zl_busy3",   64'(busy_o),             64'd0);
    check("zl_ready3",  64'(descriptor_ready_o), 64'd1);
    check("zl_count",   64'(pkt_count_o),        64'd3);
    send_desc(10'd1, 32'd0, 16'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("zl0_ready", 64'(descriptor_ready_o), 64'd1);
      check("zl0_tvalid", 64'(m_axis_tvalid_o), 64'd0);
    end

    // Payload wrap past byte 255.
    send_desc(10'd9, 32'd0, 16'd300);
    drain();

    // Random traffic; descriptors are offered while the previous packet is still in flight.
    rnd_mode = 1'b1;
    for (int k = 0; k < 24; k++) begin
      send_desc(10'($urandom), 32'($urandom_range(0, 6)), 16'($urandom_range(0, 70)));
    end
    drain();
    rnd_mode = 1'b0;

    // Reset while beat 2 of a 64-byte packet is on the bus.
    send_desc(10'd2, 32'd0, 16'd64);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("mid_rst_tvalid", 64'(m_axis_tvalid_o),    64'd0);
    check("mid_rst_count",  64'(pkt_count_o),        64'd0);
    check("mid_rst_ready",  64'(descriptor_ready_o), 64'd1);
    send_desc(10'd4, 32'd0, 16'd12);
    drain();
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
